timer_host_master: RTL and testbench



---
 rtl/timer_host_master.sv | 223 ++++++++++++++++++++++
 tb/tb_timer_host_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_host_master.sv
// Avalon-MM master that sequences the interval timer's register map for a simple command port.
// Optional snapshot op compiled in with TIMER_HOST_MASTER_SNAP_EN; without it op 2 is a no-op and snap outputs read 0.
module timer_host_master #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              timer_irq
);

    typedef enum logic [3:0] {
        IDLE,
        CFG_PL,
        CFG_PH,
        CFG_CTRL,
        STOP,
`ifdef TIMER_HOST_MASTER_SNAP_EN
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP,
`endif
        IRQ_CLR,
        IRQ_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         period_q, period_d;
    logic                cont_q, cont_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                tick_q, tick_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [2:0]          av_address_q, av_address_d;
    logic                av_chipselect_q, av_chipselect_d;
    logic                av_write_n_q, av_write_n_d;
    logic [15:0]         av_writedata_q, av_writedata_d;
`ifdef TIMER_HOST_MASTER_SNAP_EN
    logic                snap_valid_q, snap_valid_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
`endif

    always_comb begin
        state_d         = state_q;
        period_d        = period_q;
        cont_d          = cont_q;
        tick_count_d    = tick_count_q;
        cmd_ready_d     = 1'b0;
        tick_d          = 1'b0;
        av_address_d    = 3'd0;
        av_chipselect_d = 1'b0;
        av_write_n_d    = 1'b1;
        av_writedata_d  = 16'h0000;
`ifdef TIMER_HOST_MASTER_SNAP_EN
        snap_valid_d    = 1'b0;
        snap_lo_d       = snap_lo_q;
        snap_value_d    = snap_value_q;
`endif

        case (state_q)
            IDLE: begin
                // Interrupt service wins over a command presented in the same cycle.
                if (timer_irq) begin
                    state_d = IRQ_CLR;
                end else if (cmd_valid && cmd_ready_q) begin
                    period_d = cmd_period;
                    cont_d   = cmd_continuous;
                    case (cmd_op)
                        2'd0:    state_d = CFG_PL;
                        2'd1:    state_d = STOP;
`ifdef TIMER_HOST_MASTER_SNAP_EN
                        2'd2:    state_d = SNAP_WR;
`endif
                        default: state_d = IDLE;
                    endcase
                end
            end
            CFG_PL:   state_d = CFG_PH;
            CFG_PH:   state_d = CFG_CTRL;
            CFG_CTRL: state_d = IDLE;
            STOP:     state_d = IDLE;
`ifdef TIMER_HOST_MASTER_SNAP_EN
            SNAP_WR:  state_d = SNAP_RL;
            SNAP_RL:  state_d = SNAP_RH;
            SNAP_RH: begin
                snap_lo_d = av_readdata;
                state_d   = SNAP_CAP;
            end
            SNAP_CAP: begin
                snap_value_d = {av_readdata, snap_lo_q};
                state_d      = IDLE;
            end
`endif
            IRQ_CLR:  state_d = IRQ_WAIT;
            IRQ_WAIT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Bus and handshake outputs are decoded from the next state so they are registered.
        case (state_d)
            IDLE: cmd_ready_d = !timer_irq;
            CFG_PL: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd2;
                av_writedata_d  = period_d[15:0];
            end
            CFG_PH: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd3;
                av_writedata_d  = period_d[31:16];
            end
            CFG_CTRL: begin
                // Control bits {STOP, START, CONT, ITO}.
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd1;
                av_writedata_d  = {12'h000, 1'b0, 1'b1, cont_d, 1'b1};
            end
            STOP: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd1;
                av_writedata_d  = 16'h0008;
            end
`ifdef TIMER_HOST_MASTER_SNAP_EN
            SNAP_WR: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd4;
            end
            SNAP_RL: begin
                av_chipselect_d = 1'b1;
                av_address_d    = 3'd4;
            end
            SNAP_RH: begin
                av_chipselect_d = 1'b1;
                av_address_d    = 3'd5;
            end
            SNAP_CAP: snap_valid_d = 1'b1;
`endif
            IRQ_CLR: begin
                av_chipselect_d = 1'b1;
                av_write_n_d    = 1'b0;
                av_address_d    = 3'd0;
                tick_d          = 1'b1;
                tick_count_d    = tick_count_q + TICK_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            period_q        <= 32'h0;
            cont_q          <= 1'b0;
            cmd_ready_q     <= 1'b0;
            tick_q          <= 1'b0;
            tick_count_q    <= '0;
            av_address_q    <= 3'd0;
            av_chipselect_q <= 1'b0;
            av_write_n_q    <= 1'b1;
            av_writedata_q  <= 16'h0000;
`ifdef TIMER_HOST_MASTER_SNAP_EN
            snap_valid_q    <= 1'b0;
            snap_lo_q       <= 16'h0000;
            snap_value_q    <= 32'h0;
`endif
        end else begin
            state_q         <= state_d;
            period_q        <= period_d;
            cont_q          <= cont_d;
            cmd_ready_q     <= cmd_ready_d;
            tick_q          <= tick_d;
            tick_count_q    <= tick_count_d;
            av_address_q    <= av_address_d;
            av_chipselect_q <= av_chipselect_d;
            av_write_n_q    <= av_write_n_d;
            av_writedata_q  <= av_writedata_d;
`ifdef TIMER_HOST_MASTER_SNAP_EN
            snap_valid_q    <= snap_valid_d;
            snap_lo_q       <= snap_lo_d;
            snap_value_q    <= snap_value_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign tick          = tick_q;
    assign tick_count    = tick_count_q;
    assign av_address    = av_address_q;
    assign av_chipselect = av_chipselect_q;
    assign av_write_n    = av_write_n_q;
    assign av_writedata  = av_writedata_q;

`ifdef TIMER_HOST_MASTER_SNAP_EN
    // The high half only arrives in the pulse cycle, so it is forwarded from the bus while snap_valid is up.
    assign snap_valid = snap_valid_q;
    assign snap_value = snap_valid_q ? {av_readdata, snap_lo_q} : snap_value_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^av_readdata;
    assign snap_valid      = 1'b0;
    assign snap_value      = 32'h0;
`endif

endmodule

// File: tb/tb_timer_host_master.sv
// Randomized bench for timer_host_master: expected per-cycle bus/handshake traces are built from the
// command timing rules and compared cycle by cycle; a small timer slave model answers reads and clears irq.
module tb_timer_host_master;
    localparam int TW = 8;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] wd;
        logic        rdy;
        logic        tk;
        logic        sv;
    } cyc_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [31:0]   cmd_period = 32'h0;
    logic          cmd_continuous = 1'b0;
    logic          snap_valid;
    logic [31:0]   snap_value;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic [2:0]    av_address;
    logic          av_chipselect;
    logic          av_write_n;
    logic [15:0]   av_writedata;
    logic [15:0]   av_readdata = 16'h0;
    logic          timer_irq = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] exp_ticks = '0;
    logic [15:0]   snap_lo = 16'h0;
    logic [15:0]   snap_hi = 16'h0;
    int            irq_req = 0;
    int            irq_seen = 0;

    always #5 clk = ~clk;

    timer_host_master #(.TICK_W(TW)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .av_address     (av_address),
        .av_chipselect  (av_chipselect),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .timer_irq      (timer_irq)
    );

    // Timer slave: registered read data one cycle after the read, irq falls the cycle after a status write.
    always @(posedge clk) begin : slave
        logic       rd;
        logic       clr;
        logic [2:0] a;
        rd  = av_chipselect && av_write_n;
        clr = av_chipselect && !av_write_n && (av_address == 3'd0);
        a   = av_address;
        #2;
        av_readdata = !rd ? 16'h0 : (a == 3'd4) ? snap_lo : (a == 3'd5) ? snap_hi : 16'h0;
        if (clr) timer_irq = 1'b0;
        if (irq_req != irq_seen) begin
            timer_irq = 1'b1;
            irq_seen  = irq_req;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t idle_c(input logic rdy);
        cyc_t r;
        r = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, wd: 16'h0, rdy: rdy, tk: 1'b0, sv: 1'b0};
        return r;
    endfunction

    function automatic cyc_t wr_c(input logic [2:0] a, input logic [15:0] d);
        cyc_t r;
        r = '{cs: 1'b1, wn: 1'b0, addr: a, wd: d, rdy: 1'b0, tk: 1'b0, sv: 1'b0};
        return r;
    endfunction

    function automatic cyc_t rd_c(input logic [2:0] a);
        cyc_t r;
        r = '{cs: 1'b1, wn: 1'b1, addr: a, wd: 16'h0, rdy: 1'b0, tk: 1'b0, sv: 1'b0};
        return r;
    endfunction

    function automatic cyc_t clr_c();
        cyc_t r;
        r    = wr_c(3'd0, 16'h0);
        r.tk = 1'b1;
        return r;
    endfunction

    function automatic cyc_t snap_c();
        cyc_t r;
        r    = idle_c(1'b0);
        r.sv = 1'b1;
        return r;
    endfunction

    // Check the current cycle's outputs, then advance to just after the next rising edge.
    task automatic cyc(input cyc_t e);
        cyc_t g;
        @(negedge clk);
        g = '{cs: av_chipselect, wn: av_write_n, addr: av_address, wd: av_writedata,
              rdy: cmd_ready, tk: tick, sv: snap_valid};
        chk("bus_cycle", 32'(g), 32'(e));
        if (e.tk) exp_ticks = exp_ticks + 1'b1;
        chk("tick_count", 32'(tick_count), 32'(exp_ticks));
        if (e.sv) chk("snap_value", snap_value, {snap_hi, snap_lo});
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] p, input logic c, input bit irq_mid);
        cyc_t q[$];
        for (int n = 0; n < 50 && !cmd_ready; n++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid      = 1'b1;
        cmd_op         = op;
        cmd_period     = p;
        cmd_continuous = c;
        @(posedge clk);
        #1;
        cmd_valid      = 1'b0;
        cmd_op         = 2'($urandom);
        cmd_period     = $urandom;
        cmd_continuous = 1'($urandom);
        case (op)
            2'd0: q = {wr_c(3'd2, p[15:0]), wr_c(3'd3, p[31:16]),
                       wr_c(3'd1, c ? 16'h0007 : 16'h0005), idle_c(1'b1)};
            2'd1: q = {wr_c(3'd1, 16'h0008), idle_c(1'b1)};
`ifdef TIMER_HOST_MASTER_SNAP_EN
            2'd2: q = {wr_c(3'd4, 16'h0), rd_c(3'd4), rd_c(3'd5), snap_c(), idle_c(1'b1)};
`endif
            default: q = {idle_c(1'b1)};
        endcase
        if (irq_mid) begin
            irq_req++;
            if (q.size() > 1) q[q.size()-1].rdy = 1'b0;
            q.push_back(clr_c());
            q.push_back(idle_c(1'b0));
            q.push_back(idle_c(1'b1));
        end
        foreach (q[i]) cyc(q[i]);
    endtask

    task automatic irq_service();
        irq_req++;
        cyc(idle_c(1'b1));
        cyc(clr_c());
        cyc(idle_c(1'b0));
        cyc(idle_c(1'b1));
    endtask

    initial begin
        logic [31:0] p;
        repeat (3) @(posedge clk);
        #1;
        cyc(idle_c(1'b0));
        chk("snap_value_reset", snap_value, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(idle_c(1'b1));

        run_cmd(2'd0, 32'h005F5E0F, 1'b1, 1'b0);
        snap_lo = 16'h1234;
        snap_hi = 16'h0056;
        run_cmd(2'd2, 32'h0, 1'b0, 1'b0);
        run_cmd(2'd1, 32'h0, 1'b0, 1'b0);
        run_cmd(2'd3, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Command and interrupt arrive in the same cycle: interrupt first, command accepted afterwards.
        p              = 32'hA5C3_0F1E;
        cmd_valid      = 1'b1;
        cmd_op         = 2'd0;
        cmd_period     = p;
        cmd_continuous = 1'b0;
        irq_req++;
        cyc(idle_c(1'b1));
        cyc(clr_c());
        cyc(idle_c(1'b0));
        cyc(idle_c(1'b1));
        cmd_valid = 1'b0;
        cyc(wr_c(3'd2, p[15:0]));
        cyc(wr_c(3'd3, p[31:16]));
        cyc(wr_c(3'd1, 16'h0005));
        cyc(idle_c(1'b1));

        for (int i = 0; i < 60; i++) begin
            snap_lo = 16'($urandom);
            snap_hi = 16'($urandom);
            if ($urandom_range(0, 9) < 7)
                run_cmd(2'($urandom), $urandom, 1'($urandom), $urandom_range(0, 3) == 0);
            else
                irq_service();
        end

        // Enough interrupts to carry the counter through all-ones back to zero.
        for (int i = 0; i < (1 << TW); i++) irq_service();

        // Reset during the high-period write abandons the configure sequence.
        p = $urandom;
        for (int n = 0; n < 50 && !cmd_ready; n++) begin
            @(posedge clk);
            #1;
        end
        cmd_valid      = 1'b1;
        cmd_op         = 2'd0;
        cmd_period     = p;
        cmd_continuous = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc(wr_c(3'd2, p[15:0]));
        reset = 1'b1;
        cyc(wr_c(3'd3, p[31:16]));
        reset     = 1'b0;
        exp_ticks = '0;
        cyc(idle_c(1'b0));
        cyc(idle_c(1'b1));
        cyc(idle_c(1'b1));

        run_cmd(2'd0, 32'h0000_0001, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
